// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART buffering stage.
// Byte type, TX sequencer states and a width helper for occupancy counters.
package uart_pkg;

   typedef logic [7:0] uart_byte_t;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } tx_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and occupancy count.
// Pointers carry one extra bit so that full and empty are distinguishable.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        rd_data,
   output logic                    empty,
   output logic                    full,
   output logic [clog2(DEPTH):0]   count
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             push_ok;
   logic             pop_ok;

   assign count   = wr_ptr_reg - rd_ptr_reg;
   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign pop_ok  = pop & ~empty;
   // A push into a full FIFO is only allowed when the head leaves in the same cycle.
   assign push_ok = push & (~full | pop_ok);
   assign rd_data = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Buffering and flow control between host byte streams and the UART TX/RX pair.
// TX FIFO feeds a start/busy handshake sequencer; RX FIFO captures acknowledged bytes.
module uart_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tx_valid,
   input  logic [7:0]                  tx_data,
   output logic                        tx_ready,
   output logic                        rx_valid,
   output logic [7:0]                  rx_data,
   input  logic                        rx_ready,
   output logic [clog2(TX_DEPTH):0]    tx_count,
   output logic [clog2(RX_DEPTH):0]    rx_count,
   output logic                        tx_idle,
   output logic                        rx_overrun,
   input  logic                        overrun_clr,
   output logic                        txd_start,
   output logic [7:0]                  txd_data,
   input  logic                        txd_busy,
   input  logic                        rxd_ready,
   input  logic [7:0]                  rxd_data,
   output logic                        rxd_clear
);

   tx_state_t  state_reg;
   tx_state_t  state_next;
   uart_byte_t tx_head;
   uart_byte_t txd_data_reg;
   logic       txd_start_reg;
   logic       tx_empty;
   logic       tx_full;
   logic       tx_pop;
   logic       rx_empty;
   logic       rx_full;
   logic       capture;
   logic       rxd_clear_reg;
   logic       rx_overrun_reg;
   logic       overrun_set;

   uart_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (tx_valid),
      .wr_data (tx_data),
      .pop     (tx_pop),
      .rd_data (tx_head),
      .empty   (tx_empty),
      .full    (tx_full),
      .count   (tx_count)
   );

   assign tx_ready = ~tx_full;
   assign tx_pop   = (state_reg == START);
   assign tx_idle  = tx_empty & (state_reg == IDLE) & ~txd_busy;

   // WAIT_BUSY covers the cycle before the transmitter reports busy, avoiding a double start.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (!tx_empty && !txd_busy) state_next = START;
         START:     state_next = WAIT_BUSY;
         WAIT_BUSY: if (txd_busy) state_next = WAIT_DONE;
         WAIT_DONE: if (!txd_busy) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         txd_start_reg <= 1'b0;
         txd_data_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         txd_start_reg <= (state_next == START);
         if (state_next == START) txd_data_reg <= tx_head;
      end
   end

   assign txd_start = txd_start_reg;
   assign txd_data  = txd_data_reg;

   // The pending acknowledge masks rxd_ready so each byte is captured once.
   assign capture     = rxd_ready & ~rxd_clear_reg;
   assign overrun_set = capture & rx_full & ~rx_ready;

   uart_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (capture),
      .wr_data (rxd_data),
      .pop     (rx_ready),
      .rd_data (rx_data),
      .empty   (rx_empty),
      .full    (rx_full),
      .count   (rx_count)
   );

   assign rx_valid = ~rx_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_clear_reg  <= 1'b0;
         rx_overrun_reg <= 1'b0;
      end else begin
         rxd_clear_reg <= capture;
         if (overrun_set)      rx_overrun_reg <= 1'b1;
         else if (overrun_clr) rx_overrun_reg <= 1'b0;
      end
   end

   assign rxd_clear  = rxd_clear_reg;
   assign rx_overrun = rx_overrun_reg;

endmodule
